// File: rtl/maxpool2x2_stream_pkg.sv
// Shared parameters and helpers for the 2x2 stride-2 max-pool stage.
package maxpool2x2_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned IMG_WIDTH_DEF  = 32;
    localparam int unsigned IMG_HEIGHT_DEF = 32;
    localparam int unsigned POOL_K         = 2;

    typedef logic signed [DATA_WIDTH_DEF-1:0] pixel_t;

    // Address width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_row_buffer.sv
// Half-row buffer holding the horizontal maxima of the current even row.
module maxpool2x2_stream_row_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic signed [DATA_WIDTH-1:0] rd_data_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents need no reset since every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read port.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max pooling over a raster-order pixel stream.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic signed [DATA_WIDTH-1:0] s_axis_data,
    output logic                         m_axis_valid,
    input  logic                         m_axis_ready,
    output logic signed [DATA_WIDTH-1:0] m_axis_data,
    output logic                         m_axis_last
);

    localparam int unsigned COL_W     = clog2_min1(IMG_WIDTH);
    localparam int unsigned ROW_W     = clog2_min1(IMG_HEIGHT);
    localparam int unsigned BUF_DEPTH = IMG_WIDTH / POOL_K;
    localparam int unsigned ADDR_W    = clog2_min1(BUF_DEPTH);

    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
    logic                         valid_q, valid_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         last_q, last_d;

    logic                         in_hs, out_hs;
    logic                         col_last, row_last;
    logic                         emit, buf_wr;
    logic [ADDR_W-1:0]            buf_addr;
    logic signed [DATA_WIDTH-1:0] hmax, vmax, buf_rd;

    // Handshakes and position decode; input may enter whenever the output slot frees.
    assign s_axis_ready = !valid_q || m_axis_ready;
    assign in_hs        = s_axis_valid && s_axis_ready;
    assign out_hs       = valid_q && m_axis_ready;
    assign col_last     = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last     = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign emit         = in_hs && col_q[0] && row_q[0];
    assign buf_wr       = in_hs && col_q[0] && !row_q[0];
    assign buf_addr     = ADDR_W'(col_q >> 1);

    // Horizontal max of the pixel pair, then vertical max against the buffered even row.
    assign hmax = (pair_q > s_axis_data) ? pair_q : s_axis_data;
    assign vmax = (buf_rd > hmax) ? buf_rd : hmax;

    maxpool2x2_stream_row_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_row_buffer (
        .clk       (clk),
        .wr_en_i   (buf_wr),
        .wr_addr_i (buf_addr),
        .wr_data_i (hmax),
        .rd_addr_i (buf_addr),
        .rd_data_o (buf_rd)
    );

    // Next-state for raster counters, pair register and output slot.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;

        if (in_hs) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                pair_d = s_axis_data;
            end
        end

        if (emit) begin
            valid_d = 1'b1;
            data_d  = vmax;
            last_d  = row_last && col_last;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign m_axis_last  = last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed and randomized-handshake checks for maxpool2x2_stream.
module tb_maxpool2x2_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4x2 instance
    logic               a_valid, a_sready, a_mvalid, a_mready, a_mlast;
    logic signed [15:0] a_data, a_mdata;
    // 8x8 instance
    logic               b_valid, b_sready, b_mvalid, b_mready, b_mlast;
    logic signed [15:0] b_data, b_mdata;

    maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (a_valid),
        .s_axis_ready (a_sready),
        .s_axis_data  (a_data),
        .m_axis_valid (a_mvalid),
        .m_axis_ready (a_mready),
        .m_axis_data  (a_mdata),
        .m_axis_last  (a_mlast)
    );

    maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (b_valid),
        .s_axis_ready (b_sready),
        .s_axis_data  (b_data),
        .m_axis_valid (b_mvalid),
        .m_axis_ready (b_mready),
        .m_axis_data  (b_mdata),
        .m_axis_last  (b_mlast)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic signed [15:0] d, input logic l);
        check({tag, "_valid"}, a_mvalid, v);
        check({tag, "_data"},  a_mdata,  d);
        check({tag, "_last"},  a_mlast,  l);
    endtask

    // Present one pixel and hold it until accepted (bounded).
    task automatic push_a(input logic signed [15:0] d);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = d;
        #0;
        while (!a_sready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push_timeout", 1, 0);
        tick();
        a_valid = 1'b0;
        a_data  = 'x;
    endtask

    logic signed [15:0] fr [8];
    logic signed [15:0] pix [64];
    logic signed [15:0] expv [16];

    initial begin
        int c0;
        int si, ko, guard;
        logic acc;
        logic signed [15:0] m;

        a_valid = 1'b0; a_data = '0; a_mready = 1'b1;
        b_valid = 1'b0; b_data = '0; b_mready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_a("reset", 1'b0, 16'sd0, 1'b0);
        check("reset_sready", a_sready, 1);
        rst = 1'b0;
        tick();

        // Basic 4x2 frame with latency checks
        push_a(1); push_a(5); push_a(2); push_a(3);
        push_a(4); push_a(0);
        chk_a("t1_out0", 1'b1, 16'sd5, 1'b0);
        push_a(7);
        check("t1_gap_valid", a_mvalid, 0);
        push_a(-1);
        chk_a("t1_out1", 1'b1, 16'sd7, 1'b1);
        tick();
        check("t1_drain_valid", a_mvalid, 0);

        // All-negative frame: signed compare
        push_a(-8); push_a(-3); push_a(-9); push_a(-2);
        push_a(-5); push_a(-7);
        chk_a("t2_out0", 1'b1, -16'sd3, 1'b0);
        push_a(-1); push_a(-6);
        chk_a("t2_out1", 1'b1, -16'sd1, 1'b1);

        // Backpressure
        push_a(1); push_a(5); push_a(2); push_a(3);
        push_a(4); push_a(0);
        a_mready = 1'b0;
        #1;
        check("t3_sready_low", a_sready, 0);
        a_valid = 1'b1;
        a_data  = 7;
        repeat (3) tick();
        chk_a("t3_hold", 1'b1, 16'sd5, 1'b0);
        check("t3_hold_sready", a_sready, 0);
        a_mready = 1'b1;
        tick();
        a_valid = 1'b0;
        a_data  = 'x;
        check("t3_consumed_valid", a_mvalid, 0);
        push_a(-1);
        chk_a("t3_out1", 1'b1, 16'sd7, 1'b1);

        // Back-to-back frames, no gaps
        fr = '{16'sd1, 16'sd5, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd7, -16'sd1};
        c0 = cyc;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                push_a(fr[i]);
                if (i == 5) chk_a("t4_out0", 1'b1, 16'sd5, 1'b0);
                if (i == 7) chk_a("t4_out1", 1'b1, 16'sd7, 1'b1);
            end
        end
        check("t4_cycles", cyc - c0, 16);

        // Reset mid-frame drops pending output and restarts counters
        push_a(1); push_a(5); push_a(2); push_a(3);
        push_a(4); push_a(0);
        a_mready = 1'b0;
        #1;
        check("t5_pending_valid", a_mvalid, 1);
        rst = 1'b1;
        #1;
        chk_a("t5_cleared", 1'b0, 16'sd0, 1'b0);
        tick();
        rst = 1'b0;
        a_mready = 1'b1;
        tick();
        push_a(9); push_a(9); push_a(9); push_a(9);
        push_a(9); push_a(9);
        chk_a("t5_out0", 1'b1, 16'sd9, 1'b0);
        push_a(9); push_a(100);
        chk_a("t5_out1", 1'b1, 16'sd100, 1'b1);

        // Random handshakes on 8x8 frame against a reference pooling model
        for (int i = 0; i < 64; i++) pix[i] = 16'($urandom);
        for (int br = 0; br < 4; br++) begin
            for (int bc = 0; bc < 4; bc++) begin
                m = pix[(2*br)*8 + 2*bc];
                if (pix[(2*br)*8 + 2*bc + 1] > m)   m = pix[(2*br)*8 + 2*bc + 1];
                if (pix[(2*br+1)*8 + 2*bc] > m)     m = pix[(2*br+1)*8 + 2*bc];
                if (pix[(2*br+1)*8 + 2*bc + 1] > m) m = pix[(2*br+1)*8 + 2*bc + 1];
                expv[br*4 + bc] = m;
            end
        end
        si = 0; ko = 0; guard = 0;
        b_valid = 1'b0;
        b_data  = 'x;
        while (ko < 16 && guard < 3000) begin
            b_mready = ($urandom_range(0, 3) != 0);
            if (!b_valid && si < 64 && $urandom_range(0, 3) != 0) begin
                b_valid = 1'b1;
                b_data  = pix[si];
            end
            #1;
            if (b_mvalid && b_mready) begin
                check("t6_data", b_mdata, expv[ko]);
                check("t6_last", b_mlast, (ko == 15) ? 1 : 0);
                ko++;
            end
            acc = b_valid && b_sready;
            tick();
            if (acc) begin
                si++;
                b_valid = 1'b0;
                b_data  = 'x;
            end
            guard++;
        end
        check("t6_outputs", ko, 16);
        check("t6_inputs", si, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
